sixteen_to_one_deserializer_fsm: RTL and testbench
==================================================

SIXTEEN_TO_ONE_DESERIALIZER_FSM -- requirements
Module: sixteen_to_one_deserializer_fsm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the frame length in bits.
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the bit-counter width, equal to clog2(WIDTH).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: frame-begin request.
REQ-006 The block SHALL have port ss, input, 1 bit: bit strobe/select; a bit is sampled only in cycles where ss=1.
REQ-007 The block SHALL have port data_input, input, 1 bit: serial data, MSB of the frame first.
REQ-008 The block SHALL have port data_output, output, WIDTH bits: last completed frame, held until the next frame completes.
REQ-009 The block SHALL have port data_received, output, 1 bit: one-cycle pulse marking a new data_output.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in RECV.
REQ-011 The block SHALL have port bit_count, output, CNT_W bits: number of bits captured in the current frame.
REQ-012 The block SHALL have port frame_error, output, 1 bit: sticky flag for an aborted frame.
REQ-013 The block SHALL have port y_Q, output, 2 bits: present state.
REQ-014 The block SHALL have port Y_D, output, 2 bits: next state (combinational).
REQ-015 The block SHALL have port allOfDataIn, output, WIDTH bits: live shift-register contents.

Function
REQ-016 State encoding SHALL be IDLE=00, RECV=01, DONE=10; the code 11 SHALL have next state IDLE.
REQ-017 In IDLE, start=1 SHALL move the FSM to RECV on the next edge, with bit_count cleared to 0 and the shift register cleared to 0.
REQ-018 In RECV, ss=1 SHALL shift data_input into the LSB (the register shifts left) and increment bit_count; ss=0 SHALL hold all state.
REQ-019 In RECV, an ss=1 cycle at bit_count=WIDTH-1 SHALL, on the same edge, copy the completed shift value into data_output and move the FSM to DONE.
REQ-020 Latency SHALL be: data_output and data_received become valid on the edge after the 16th sampled bit; data_received is high only while in DONE.
REQ-021 DONE SHALL last exactly one cycle; the next state is RECV if start=1 (restart as in REQ-017), otherwise IDLE.
REQ-022 In RECV, start=1 SHALL abort and restart the frame: bit_count goes to 0, the shift register clears, frame_error goes to 1, and no data_received pulse occurs; in that cycle start takes priority over ss.
REQ-023 frame_error SHALL clear on the next DONE entry, i.e. the next completed frame.
REQ-024 In IDLE and DONE, ss and data_input SHALL be ignored.
REQ-025 bit_count SHALL never exceed WIDTH-1 and SHALL wrap to 0 only via REQ-017, REQ-021 or REQ-022.

Reset
REQ-026 resetn=0 SHALL immediately force: y_Q=IDLE, data_output=0, shift register=0, bit_count=0, frame_error=0, data_received=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame, and no data_received pulse SHALL follow release.
REQ-028 After resetn rises, the first start SHALL be accepted on the next rising edge.

Structure
REQ-029 The state encodings (IDLE, RECV, DONE) and the default WIDTH SHALL live in a shared package that the serializer also uses.
REQ-030 The SIPO shift register with clear, enable and parallel-load of data_output SHALL be a sub-module named sipo_shift_register; the FSM and counter SHALL remain in the top module.

Verification
REQ-031 Reset, then start pulse, then 16 ss=1 cycles carrying 0xA5C3 MSB-first -> data_output=0xA5C3 with a one-cycle data_received, frame_error=0, and y_Q sequence 00,01,...,10,00.
REQ-032 The same 0xA5C3 frame with ss=0 gaps of 3 cycles after bits 4 and 11 -> data_output=0xA5C3, and bit_count holds its value during the gaps.
REQ-033 8 bits of 0xFF sent, then start re-asserted, then a full 0x1234 frame -> frame_error=1 after the abort, a single data_received, data_output=0x1234, then frame_error=0.
REQ-034 resetn pulsed low after bit 9 of 0xBEEF -> all outputs 0 immediately, no data_received, and a following frame of 0x0F0F is captured correctly.
REQ-035 Back-to-back frames 0xFFFF then 0x0001 with start held high during DONE -> two data_received pulses 17 cycles apart, and data_output transitions 0xFFFF then 0x0001.
REQ-036 Loopback of the team's 16-to-1 serializer output into data_input with shared clock and ss -> the received word equals the transmitted word for 0x0000, 0xFFFF, 0x8001 and 0x5AA5.

Source files
------------

// File: rtl/sixteen_to_one_deserializer_fsm_pkg.sv
// Shared definitions for the 16-bit serializer/deserializer pair.
package sixteen_to_one_deserializer_fsm_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sixteen_to_one_deserializer_fsm_sipo.sv
// Serial-in parallel-out shift register with clear, shift enable and
// parallel capture of the completed word.
module sipo_shift_register
  import sixteen_to_one_deserializer_fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic             serial_in,
  output logic [WIDTH-1:0] shift_value,
  output logic [WIDTH-1:0] parallel_value
);

  logic [WIDTH-1:0] shift_next;

  // Value after shifting the incoming bit into the LSB.
  always_comb begin
    shift_next = {shift_value[WIDTH-2:0], serial_in};
  end

  // Shift register and output word; load captures the value including this cycle's bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_value    <= '0;
      parallel_value <= '0;
    end else begin
      if (clear) begin
        shift_value <= '0;
      end else if (enable) begin
        shift_value <= shift_next;
      end
      if (load) begin
        parallel_value <= shift_next;
      end
    end
  end

endmodule

// File: rtl/sixteen_to_one_deserializer_fsm.sv
// Frame deserializer: IDLE/RECV/DONE controller and bit counter around a SIPO.
module sixteen_to_one_deserializer_fsm
  import sixteen_to_one_deserializer_fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             ss,
  input  logic             data_input,
  output logic [WIDTH-1:0] data_output,
  output logic             data_received,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             frame_error,
  output logic [1:0]       y_Q,
  output logic [1:0]       Y_D,
  output logic [WIDTH-1:0] allOfDataIn
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count_d;
  logic             error_d;
  logic             sr_clear;
  logic             sr_enable;
  logic             sr_load;

  // Next state, counter/error updates and shift-register controls.
  // The counter holds at WIDTH-1 through DONE/IDLE so it only returns to 0 on a (re)start.
  always_comb begin
    state_d   = state_q;
    count_d   = bit_count;
    error_d   = frame_error;
    sr_clear  = 1'b0;
    sr_enable = 1'b0;
    sr_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RECV;
          count_d  = '0;
          sr_clear = 1'b1;
        end
      end
      RECV: begin
        if (start) begin
          count_d  = '0;
          sr_clear = 1'b1;
          error_d  = 1'b1;
        end else if (ss) begin
          sr_enable = 1'b1;
          if (bit_count == LAST_BIT) begin
            sr_load = 1'b1;
            state_d = DONE;
            error_d = 1'b0;
          end else begin
            count_d = bit_count + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d  = RECV;
          count_d  = '0;
          sr_clear = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bit counter and sticky abort flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      bit_count   <= '0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count   <= count_d;
      frame_error <= error_d;
    end
  end

  // Status outputs decoded from the present and next state.
  always_comb begin
    y_Q           = state_q;
    Y_D           = state_d;
    busy          = (state_q == RECV);
    data_received = (state_q == DONE);
  end

  sipo_shift_register #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clock         (clock),
    .resetn        (resetn),
    .clear         (sr_clear),
    .enable        (sr_enable),
    .load          (sr_load),
    .serial_in     (data_input),
    .shift_value   (allOfDataIn),
    .parallel_value(data_output)
  );

endmodule

// File: tb/tb_sixteen_to_one_deserializer_fsm.sv
// Directed self-checking bench for the 16-bit frame deserializer.
module tb_sixteen_to_one_deserializer_fsm;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        ss;
  logic        data_input;
  logic [15:0] data_output;
  logic        data_received;
  logic        busy;
  logic [3:0]  bit_count;
  logic        frame_error;
  logic [1:0]  y_Q;
  logic [1:0]  Y_D;
  logic [15:0] allOfDataIn;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int pulses = 0;

  sixteen_to_one_deserializer_fsm #(
    .WIDTH(16),
    .CNT_W(4)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .ss           (ss),
    .data_input   (data_input),
    .data_output  (data_output),
    .data_received(data_received),
    .busy         (busy),
    .bit_count    (bit_count),
    .frame_error  (frame_error),
    .y_Q          (y_Q),
    .Y_D          (Y_D),
    .allOfDataIn  (allOfDataIn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    cycle++;
    if (data_received === 1'b1) pulses++;
  endtask

  // Send bits hi downto lo of word with ss=1 on consecutive cycles.
  task automatic send_bits(input logic [15:0] word, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      ss = 1'b1;
      data_input = word[i];
      step();
    end
    ss = 1'b0;
    data_input = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1; start = 1'b0; ss = 1'b0; data_input = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checks++; if (y_Q !== 2'b00) begin errors++; $display("FAIL reset_yq got %b expected %b", y_Q, 2'b00); end
    checks++; if (data_output !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h expected %h", data_output, 16'h0000); end
    checks++; if (allOfDataIn !== 16'h0000) begin errors++; $display("FAIL reset_shift got %h expected %h", allOfDataIn, 16'h0000); end
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", bit_count); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b expected 0", frame_error); end
    checks++; if (data_received !== 1'b0) begin errors++; $display("FAIL reset_drcv got %b expected 0", data_received); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    step(); step();
    resetn = 1'b1;
    start_frame();
    checks++; if (y_Q !== 2'b01) begin errors++; $display("FAIL first_start_yq got %b expected %b", y_Q, 2'b01); end
    // Abandon this frame by resetting again so later tests start from IDLE.
    resetn = 1'b0;
    #1 resetn = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] w;
    w = 16'hA5C3;
    pulses = 0;
    start_frame();
    checks++; if (y_Q !== 2'b01) begin errors++; $display("FAIL basic_recv_yq got %b expected %b", y_Q, 2'b01); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b expected 1", busy); end
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL basic_count0 got %0d expected 0", bit_count); end
    for (int i = 15; i >= 0; i--) begin
      ss = 1'b1;
      data_input = w[i];
      #1;
      checks++;
      if (i == 0) begin
        if (Y_D !== 2'b10) begin errors++; $display("FAIL basic_yd_last got %b expected %b", Y_D, 2'b10); end
      end else begin
        if (Y_D !== 2'b01) begin errors++; $display("FAIL basic_yd_bit%0d got %b expected %b", i, Y_D, 2'b01); end
      end
      step();
    end
    ss = 1'b0;
    checks++; if (y_Q !== 2'b10) begin errors++; $display("FAIL basic_done_yq got %b expected %b", y_Q, 2'b10); end
    checks++; if (data_received !== 1'b1) begin errors++; $display("FAIL basic_drcv got %b expected 1", data_received); end
    checks++; if (data_output !== 16'hA5C3) begin errors++; $display("FAIL basic_dout got %h expected %h", data_output, 16'hA5C3); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b expected 0", frame_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b expected 0", busy); end
    step();
    checks++; if (y_Q !== 2'b00) begin errors++; $display("FAIL basic_idle_yq got %b expected %b", y_Q, 2'b00); end
    checks++; if (data_received !== 1'b0) begin errors++; $display("FAIL basic_drcv_low got %b expected 0", data_received); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL basic_pulses got %0d expected 1", pulses); end
    checks++; if (data_output !== 16'hA5C3) begin errors++; $display("FAIL basic_dout_hold got %h expected %h", data_output, 16'hA5C3); end
  endtask

  task automatic test_gaps();
    logic [15:0] w;
    w = 16'hA5C3;
    start_frame();
    send_bits(w, 15, 12);
    for (int g = 0; g < 3; g++) begin
      data_input = g[0];
      step();
      checks++; if (bit_count !== 4'd4) begin errors++; $display("FAIL gap1_count got %0d expected 4", bit_count); end
      checks++; if (allOfDataIn !== 16'h000A) begin errors++; $display("FAIL gap1_shift got %h expected %h", allOfDataIn, 16'h000A); end
    end
    send_bits(w, 11, 5);
    for (int g = 0; g < 3; g++) begin
      data_input = ~g[0];
      step();
      checks++; if (bit_count !== 4'd11) begin errors++; $display("FAIL gap2_count got %0d expected 11", bit_count); end
      checks++; if (allOfDataIn !== 16'h052E) begin errors++; $display("FAIL gap2_shift got %h expected %h", allOfDataIn, 16'h052E); end
    end
    send_bits(w, 4, 0);
    checks++; if (data_output !== 16'hA5C3) begin errors++; $display("FAIL gap_dout got %h expected %h", data_output, 16'hA5C3); end
    checks++; if (data_received !== 1'b1) begin errors++; $display("FAIL gap_drcv got %b expected 1", data_received); end
    step();
  endtask

  task automatic test_abort();
    pulses = 0;
    start_frame();
    send_bits(16'hFFFF, 15, 8);
    checks++; if (bit_count !== 4'd8) begin errors++; $display("FAIL abort_count8 got %0d expected 8", bit_count); end
    checks++; if (allOfDataIn !== 16'h00FF) begin errors++; $display("FAIL abort_shift got %h expected %h", allOfDataIn, 16'h00FF); end
    start = 1'b1; ss = 1'b1; data_input = 1'b1;
    #1;
    checks++; if (Y_D !== 2'b01) begin errors++; $display("FAIL abort_yd got %b expected %b", Y_D, 2'b01); end
    step();
    start = 1'b0; ss = 1'b0;
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL abort_count0 got %0d expected 0", bit_count); end
    checks++; if (allOfDataIn !== 16'h0000) begin errors++; $display("FAIL abort_clear got %h expected %h", allOfDataIn, 16'h0000); end
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL abort_ferr got %b expected 1", frame_error); end
    checks++; if (y_Q !== 2'b01) begin errors++; $display("FAIL abort_yq got %b expected %b", y_Q, 2'b01); end
    send_bits(16'h1234, 15, 1);
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL abort_ferr_sticky got %b expected 1", frame_error); end
    send_bits(16'h1234, 0, 0);
    checks++; if (data_output !== 16'h1234) begin errors++; $display("FAIL abort_dout got %h expected %h", data_output, 16'h1234); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL abort_ferr_clear got %b expected 0", frame_error); end
    step();
    checks++; if (pulses !== 1) begin errors++; $display("FAIL abort_pulses got %0d expected 1", pulses); end
  endtask

  task automatic test_reset_mid();
    pulses = 0;
    start_frame();
    send_bits(16'hBEEF, 15, 7);
    checks++; if (allOfDataIn !== 16'h017D) begin errors++; $display("FAIL mid_shift got %h expected %h", allOfDataIn, 16'h017D); end
    checks++; if (bit_count !== 4'd9) begin errors++; $display("FAIL mid_count got %0d expected 9", bit_count); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (y_Q !== 2'b00) begin errors++; $display("FAIL mid_yq got %b expected %b", y_Q, 2'b00); end
    checks++; if (data_output !== 16'h0000) begin errors++; $display("FAIL mid_dout got %h expected %h", data_output, 16'h0000); end
    checks++; if (allOfDataIn !== 16'h0000) begin errors++; $display("FAIL mid_shift0 got %h expected %h", allOfDataIn, 16'h0000); end
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL mid_count0 got %0d expected 0", bit_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b expected 0", busy); end
    step(); step();
    resetn = 1'b1;
    step(); step(); step();
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_pulses got %0d expected 0", pulses); end
    checks++; if (y_Q !== 2'b00) begin errors++; $display("FAIL mid_idle_yq got %b expected %b", y_Q, 2'b00); end
    start_frame();
    send_bits(16'h0F0F, 15, 0);
    checks++; if (data_output !== 16'h0F0F) begin errors++; $display("FAIL mid_next_dout got %h expected %h", data_output, 16'h0F0F); end
    checks++; if (data_received !== 1'b1) begin errors++; $display("FAIL mid_next_drcv got %b expected 1", data_received); end
    step();
  endtask

  task automatic test_back_to_back();
    int first;
    pulses = 0;
    start_frame();
    send_bits(16'hFFFF, 15, 0);
    first = cycle;
    checks++; if (data_received !== 1'b1) begin errors++; $display("FAIL b2b_drcv1 got %b expected 1", data_received); end
    checks++; if (data_output !== 16'hFFFF) begin errors++; $display("FAIL b2b_dout1 got %h expected %h", data_output, 16'hFFFF); end
    start = 1'b1;
    #1;
    checks++; if (Y_D !== 2'b01) begin errors++; $display("FAIL b2b_yd got %b expected %b", Y_D, 2'b01); end
    step();
    start = 1'b0;
    checks++; if (y_Q !== 2'b01) begin errors++; $display("FAIL b2b_yq got %b expected %b", y_Q, 2'b01); end
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL b2b_count got %0d expected 0", bit_count); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL b2b_ferr got %b expected 0", frame_error); end
    send_bits(16'h0001, 15, 0);
    checks++; if (data_received !== 1'b1) begin errors++; $display("FAIL b2b_drcv2 got %b expected 1", data_received); end
    checks++; if (data_output !== 16'h0001) begin errors++; $display("FAIL b2b_dout2 got %h expected %h", data_output, 16'h0001); end
    checks++; if (cycle - first !== 17) begin errors++; $display("FAIL b2b_spacing got %0d expected 17", cycle - first); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d expected 2", pulses); end
    step();
  endtask

  // A serializer model drives data_input MSB-first from its own register, sharing clock and ss.
  task automatic test_loopback();
    logic [15:0] words [4];
    logic [15:0] tx_sr;
    words[0] = 16'h0000; words[1] = 16'hFFFF; words[2] = 16'h8001; words[3] = 16'h5AA5;
    for (int k = 0; k < 4; k++) begin
      start_frame();
      tx_sr = words[k];
      for (int b = 0; b < 16; b++) begin
        ss = 1'b1;
        data_input = tx_sr[15];
        step();
        tx_sr = {tx_sr[14:0], 1'b0};
      end
      ss = 1'b0;
      checks++; if (data_output !== words[k]) begin errors++; $display("FAIL loop_dout%0d got %h expected %h", k, data_output, words[k]); end
      checks++; if (data_received !== 1'b1) begin errors++; $display("FAIL loop_drcv%0d got %b expected 1", k, data_received); end
      step();
    end
  endtask

  task automatic test_idle_ignore();
    for (int c = 0; c < 4; c++) begin
      ss = 1'b1;
      data_input = c[0];
      step();
      checks++; if (y_Q !== 2'b00) begin errors++; $display("FAIL idle_yq got %b expected %b", y_Q, 2'b00); end
      checks++; if (allOfDataIn !== 16'h5AA5) begin errors++; $display("FAIL idle_shift got %h expected %h", allOfDataIn, 16'h5AA5); end
      checks++; if (bit_count !== 4'd15) begin errors++; $display("FAIL idle_count got %0d expected 15", bit_count); end
    end
    ss = 1'b0;
    checks++; if (data_output !== 16'h5AA5) begin errors++; $display("FAIL idle_dout got %h expected %h", data_output, 16'h5AA5); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_loopback();
    test_idle_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
